// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: programmable MDC divider, configurable
// preamble (0 = suppressed), user read/write frames and an optional periodic register poll.
module mdio_master #(
    parameter int CLK_DIV       = 4,
    parameter int PREAMBLE_BITS = 32,
    parameter int POLL_INTERVAL = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [4:0]  phy_addr_i,
    input  logic [4:0]  reg_addr_i,
    input  logic [15:0] data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] data_o,
    output logic        rd_err_o,
    input  logic        poll_en_i,
    input  logic [4:0]  poll_reg_i,
    output logic [15:0] poll_data_o,
    output logic        poll_change_o,
    output logic        mdc_o,
    output logic        mdio_o,
    output logic        mdio_oe_o,
    input  logic        mdio_i
);
    localparam int DIV_W    = $clog2(2 * CLK_DIV);
    localparam int PC_W     = $clog2(POLL_INTERVAL);
    localparam int PRE_LAST = (PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0;
    localparam logic [DIV_W-1:0] SAMPLE_AT = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] MDC_HIGH  = DIV_W'(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, TA, DATA, END} state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        bit_cnt;
    logic [31:0]       tx_sr;
    logic [15:0]       rx_sr;
    logic              is_read;
    logic              is_poll;
    logic              ta_err;
    logic [PC_W-1:0]   poll_cnt;
    logic              busy;
    logic              bit_end;
    logic              sample_now;
    logic              op_legal;
    logic              accept_user;
    logic              launch_poll;
    logic              frame_last;
    logic              drive;

    assign busy        = (state != IDLE);
    assign bit_end     = busy && (div_cnt == DIV_LAST);
    // mdio_i is captured on the clk edge that raises MDC
    assign sample_now  = busy && (div_cnt == SAMPLE_AT);
    assign op_legal    = (op_i == 2'b01) || (op_i == 2'b10);
    assign accept_user = (state == IDLE) && start_i && op_legal;
    assign launch_poll = (state == IDLE) && poll_en_i && (poll_cnt == POLL_LAST) && !accept_user;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        frame_last = 1'b0;
        case (state)
            IDLE:     if (accept_user || launch_poll)
                          state_next = (PREAMBLE_BITS == 0) ? HEADER : PREAMBLE;
            PREAMBLE: if (bit_end && bit_cnt == 5'(PRE_LAST)) state_next = HEADER;
            HEADER:   if (bit_end && bit_cnt == 5'd13) state_next = TA;
            TA:       if (bit_end && bit_cnt == 5'd1) state_next = DATA;
            DATA:     if (bit_end && bit_cnt == 5'd15) state_next = END;
            END: begin
                if (bit_end) begin
                    state_next = IDLE;
                    frame_last = 1'b1;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt       <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            is_read       <= 1'b0;
            is_poll       <= 1'b0;
            ta_err        <= 1'b0;
            poll_cnt      <= '0;
            done_o        <= 1'b0;
            data_o        <= '0;
            rd_err_o      <= 1'b0;
            poll_data_o   <= '0;
            poll_change_o <= 1'b0;
        end else begin
            done_o        <= 1'b0;
            poll_change_o <= 1'b0;

            if (!busy || div_cnt == DIV_LAST) div_cnt <= '0;
            else                              div_cnt <= div_cnt + 1'b1;

            if (state_next != state) bit_cnt <= '0;
            else if (bit_end)        bit_cnt <= bit_cnt + 1'b1;

            if (accept_user) begin
                tx_sr   <= {2'b01, op_i, phy_addr_i, reg_addr_i, 2'b10, data_i};
                is_read <= (op_i == 2'b10);
                is_poll <= 1'b0;
            end else if (launch_poll) begin
                tx_sr   <= {2'b01, 2'b10, phy_addr_i, poll_reg_i, 2'b10, 16'h0000};
                is_read <= 1'b1;
                is_poll <= 1'b1;
            end else if (bit_end && (state == HEADER || state == TA || state == DATA)) begin
                tx_sr <= {tx_sr[30:0], 1'b0};
            end

            if (sample_now && state == TA && bit_cnt == 5'd1) ta_err <= mdio_i;
            if (sample_now && state == DATA) rx_sr <= {rx_sr[14:0], mdio_i};

            // Poll results are filtered; user results are reported as sampled
            if (frame_last) begin
                if (is_poll) begin
                    if (!ta_err && rx_sr != poll_data_o) begin
                        poll_data_o   <= rx_sr;
                        poll_change_o <= 1'b1;
                    end
                end else begin
                    done_o <= 1'b1;
                    if (is_read) begin
                        data_o   <= rx_sr;
                        rd_err_o <= ta_err;
                    end
                end
            end

            if (!poll_en_i || launch_poll)                 poll_cnt <= '0;
            else if (state == IDLE && poll_cnt != POLL_LAST) poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_comb begin
        drive  = 1'b0;
        mdio_o = 1'b1;
        case (state)
            PREAMBLE: drive = 1'b1;
            HEADER: begin
                drive  = 1'b1;
                mdio_o = tx_sr[31];
            end
            TA, DATA: begin
                if (!is_read) begin
                    drive  = 1'b1;
                    mdio_o = tx_sr[31];
                end
            end
            default: ;
        endcase
    end

    // The bus is released combinationally as soon as reset is asserted
    assign mdio_oe_o = drive && rst_n;
    assign mdc_o     = busy && (div_cnt >= MDC_HIGH);
    assign busy_o    = busy;
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: a 32-bit-preamble instance with a behavioural PHY and
// a preamble-suppressed CLK_DIV=1 instance; expected frames and results are queued.
module tb_mdio_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0;
    logic [1:0]  op_a = 2'b00;
    logic [4:0]  phy_addr = 5'd1;
    logic [4:0]  reg_a = 5'd0;
    logic [15:0] wdata_a = 16'h0;
    logic        busy_a, done_a, rd_err_a;
    logic [15:0] rdata_a;
    logic        poll_en = 1'b0;
    logic [4:0]  poll_reg = 5'd1;
    logic [15:0] poll_data;
    logic        poll_change;
    logic        mdc_a, mdio_o_a, mdio_oe_a;
    logic        mdio_i_a = 1'b1;

    logic        start_b = 1'b0;
    logic [1:0]  op_b = 2'b00;
    logic [4:0]  reg_b = 5'd0;
    logic [15:0] wdata_b = 16'h0;
    logic        busy_b, done_b, rd_err_b;
    logic [15:0] rdata_b, poll_data_b;
    logic        poll_change_b;
    logic        mdc_b, mdio_o_b, mdio_oe_b;
    logic        mdio_i_b = 1'b1;
    logic        poll_en_b = 1'b0;

    mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(32), .POLL_INTERVAL(1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_a), .op_i(op_a),
        .phy_addr_i(phy_addr), .reg_addr_i(reg_a), .data_i(wdata_a),
        .busy_o(busy_a), .done_o(done_a), .data_o(rdata_a), .rd_err_o(rd_err_a),
        .poll_en_i(poll_en), .poll_reg_i(poll_reg), .poll_data_o(poll_data),
        .poll_change_o(poll_change), .mdc_o(mdc_a), .mdio_o(mdio_o_a),
        .mdio_oe_o(mdio_oe_a), .mdio_i(mdio_i_a));

    mdio_master #(.CLK_DIV(1), .PREAMBLE_BITS(0), .POLL_INTERVAL(1000)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .op_i(op_b),
        .phy_addr_i(phy_addr), .reg_addr_i(reg_b), .data_i(wdata_b),
        .busy_o(busy_b), .done_o(done_b), .data_o(rdata_b), .rd_err_o(rd_err_b),
        .poll_en_i(poll_en_b), .poll_reg_i(poll_reg), .poll_data_o(poll_data_b),
        .poll_change_o(poll_change_b), .mdc_o(mdc_b), .mdio_o(mdio_o_b),
        .mdio_oe_o(mdio_oe_b), .mdio_i(mdio_i_b));

    int n_checks = 0;
    int n_fails = 0;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
    } rd_exp_t;
    rd_exp_t     rd_q[$];
    logic [15:0] poll_q[$];
    logic [1:0]  bit_q[$];

    // Behavioural PHY for dut_a: decodes OP/REGAD, answers reads after MDC rises
    logic [15:0] phy_regs [32];
    bit          phy_present = 1'b1;
    int          pbit = 0;
    logic [1:0]  ph_op = 2'b00;
    logic [4:0]  ph_reg = 5'd0;
    logic [15:0] ph_val = 16'h0;
    bit          busy_prev = 1'b0;
    bit          mdc_prev = 1'b0;

    always @(negedge clk) begin
        if (!busy_a) mdio_i_a = 1'b1;
        if (busy_a && !busy_prev) pbit = 0;
        if (mdc_a && !mdc_prev) begin
            if (pbit == 34 || pbit == 35) ph_op = {ph_op[0], mdio_o_a};
            if (pbit >= 41 && pbit <= 45) ph_reg = {ph_reg[3:0], mdio_o_a};
            if (pbit == 45) ph_val = phy_regs[ph_reg];
            if (phy_present && ph_op == 2'b10) begin
                if (pbit == 46)                    mdio_i_a = 1'b0;
                else if (pbit >= 47 && pbit <= 62) mdio_i_a = ph_val[4'(62 - pbit)];
                else                               mdio_i_a = 1'b1;
            end else begin
                mdio_i_a = 1'b1;
            end
            pbit++;
        end
        busy_prev = busy_a;
        mdc_prev  = mdc_a;
    end

    task automatic push_frame(input int pre, input logic [13:0] hdr,
                              input logic [17:0] tail, input bit drive_tail);
        for (int i = 0; i < pre; i++) bit_q.push_back(2'b11);
        for (int i = 13; i >= 0; i--) bit_q.push_back({1'b1, hdr[i]});
        for (int i = 17; i >= 0; i--) bit_q.push_back({drive_tail, drive_tail ? tail[i] : 1'b1});
        bit_q.push_back(2'b01);
    endtask

    // Runs one user frame on dut_a; returns done latency (-1 on timeout) and bit errors
    task automatic run_user(input logic [1:0] op, input logic [4:0] rg, input logic [15:0] wd,
                            output int lat, output int bad);
        logic       pm;
        logic [1:0] e;
        @(negedge clk);
        op_a = op; reg_a = rg; wdata_a = wd; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = -1; bad = 0; pm = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (done_a) begin lat = n; break; end
            if (mdc_a && !pm) begin
                if (bit_q.size() == 0) bad++;
                else begin
                    e = bit_q.pop_front();
                    if (mdio_oe_a !== e[1] || (e[1] && mdio_o_a !== e[0])) bad++;
                end
            end
            pm = mdc_a;
            @(negedge clk);
        end
        bad += bit_q.size();
        bit_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mdc_a, mdio_o_a, mdio_oe_a, busy_a, done_a, rd_err_a, poll_change} !== 7'b0100000) begin
            n_fails++;
            $display("[TB] FAIL reset_ctl_a: got %b expected 0100000",
                     {mdc_a, mdio_o_a, mdio_oe_a, busy_a, done_a, rd_err_a, poll_change});
        end
        n_checks++;
        if (rdata_a !== 16'h0 || poll_data !== 16'h0) begin
            n_fails++;
            $display("[TB] FAIL reset_data_a: got %h/%h expected 0000/0000", rdata_a, poll_data);
        end
        n_checks++;
        if ({mdc_b, mdio_o_b, mdio_oe_b, busy_b, done_b} !== 5'b01000) begin
            n_fails++;
            $display("[TB] FAIL reset_ctl_b: got %b expected 01000",
                     {mdc_b, mdio_o_b, mdio_oe_b, busy_b, done_b});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        int lat, bad;
        push_frame(32, 14'b01_01_00001_00000, 18'b10_0001001000000000, 1'b1);
        run_user(2'b01, 5'd0, 16'h1200, lat, bad);
        n_checks++;
        if (lat != 260) begin n_fails++; $display("[TB] FAIL write_latency: got %0d expected 260", lat); end
        n_checks++;
        if (bad != 0) begin n_fails++; $display("[TB] FAIL write_stream: got %0d bad bits expected 0", bad); end
        n_checks++;
        if (busy_a !== 1'b0) begin n_fails++; $display("[TB] FAIL write_busy_at_done: got %b expected 0", busy_a); end
        @(negedge clk);
        n_checks++;
        if (done_a !== 1'b0 || rdata_a !== 16'h0) begin
            n_fails++;
            $display("[TB] FAIL write_done_pulse: got done=%b data=%h expected done=0 data=0000", done_a, rdata_a);
        end
    endtask

    task automatic test_read(input bit present, input logic [15:0] exp_data, input logic exp_err);
        int      lat, bad;
        rd_exp_t e;
        phy_present = present;
        e.data = exp_data; e.err = exp_err;
        rd_q.push_back(e);
        push_frame(32, 14'b01_10_00001_00010, 18'h0, 1'b0);
        run_user(2'b10, 5'd2, 16'h0, lat, bad);
        n_checks++;
        if (lat != 260 || bad != 0) begin
            n_fails++;
            $display("[TB] FAIL read_frame: got latency %0d bad %0d expected 260/0", lat, bad);
        end
        e = rd_q.pop_front();
        n_checks++;
        if (rdata_a !== e.data || rd_err_a !== e.err) begin
            n_fails++;
            $display("[TB] FAIL read_result: got %h err %b expected %h err %b", rdata_a, rd_err_a, e.data, e.err);
        end
        phy_present = 1'b1;
    endtask

    task automatic test_poll;
        int          frames, pulses, dones;
        logic [15:0] exp;
        logic        bp;
        frames = 0; pulses = 0; dones = 0; bp = 1'b0;
        phy_regs[1] = 16'h7849;
        poll_q.push_back(16'h7849);
        poll_q.push_back(16'h786D);
        poll_en = 1'b1;
        for (int n = 0; n < 8000; n++) begin
            @(negedge clk);
            if (done_a) dones++;
            if (poll_change) begin
                pulses++;
                exp = (poll_q.size() != 0) ? poll_q.pop_front() : 16'hxxxx;
                n_checks++;
                if (poll_data !== exp) begin
                    n_fails++;
                    $display("[TB] FAIL poll_value: got %h expected %h", poll_data, exp);
                end
            end
            if (bp && !busy_a) begin
                frames++;
                if (frames == 3) phy_regs[1] = 16'h786D;
                if (frames == 4) break;
            end
            bp = busy_a;
        end
        n_checks++;
        if (frames != 4 || pulses != 2) begin
            n_fails++;
            $display("[TB] FAIL poll_count: got %0d frames %0d pulses expected 4/2", frames, pulses);
        end
        n_checks++;
        if (dones != 0 || rdata_a !== 16'hFFFF || rd_err_a !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL poll_isolation: got done %0d data %h err %b expected 0 FFFF 1", dones, rdata_a, rd_err_a);
        end
        poll_q.delete();
    endtask

    task automatic test_collision;
        int      lat, dones, pulses, activity;
        rd_exp_t e;
        // Poll counter is 0 in the current cycle; the request lands on count 999
        repeat (999) @(negedge clk);
        e.data = 16'h0022; e.err = 1'b0;
        rd_q.push_back(e);
        op_a = 2'b10; reg_a = 5'd2; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n_checks++;
        if (busy_a !== 1'b1) begin n_fails++; $display("[TB] FAIL collide_accept: got busy %b expected 1", busy_a); end
        lat = -1;
        for (int n = 0; n < 2000; n++) begin
            if (done_a) begin lat = n; break; end
            start_a = (n == 100);
            op_a = 2'b01;
            @(negedge clk);
        end
        start_a = 1'b0;
        e = rd_q.pop_front();
        n_checks++;
        if (lat != 260 || rdata_a !== e.data || rd_err_a !== e.err) begin
            n_fails++;
            $display("[TB] FAIL collide_user_first: got lat %0d data %h err %b expected 260 %h %b",
                     lat, rdata_a, rd_err_a, e.data, e.err);
        end
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1) begin n_fails++; $display("[TB] FAIL collide_poll_next: got busy %b expected 1", busy_a); end
        poll_en = 1'b0;
        dones = 0; pulses = 0;
        for (int n = 0; n < 2000; n++) begin
            if (done_a) dones++;
            if (poll_change) pulses++;
            if (!busy_a) break;
            @(negedge clk);
        end
        n_checks++;
        if (busy_a !== 1'b0 || dones != 0 || pulses != 0 || poll_data !== 16'h786D) begin
            n_fails++;
            $display("[TB] FAIL collide_poll_frame: got busy %b done %0d chg %0d data %h expected 0 0 0 786D",
                     busy_a, dones, pulses, poll_data);
        end
        activity = 0;
        repeat (400) begin
            @(negedge clk);
            if (busy_a || done_a || poll_change) activity++;
        end
        n_checks++;
        if (activity != 0) begin n_fails++; $display("[TB] FAIL ignored_start: got %0d active cycles expected 0", activity); end
    endtask

    task automatic test_illegal_op;
        int activity;
        activity = 0;
        foreach (op_a[i]) ;
        @(negedge clk);
        op_a = 2'b11; start_a = 1'b1;
        @(negedge clk);
        op_a = 2'b00;
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) begin
            if (busy_a || done_a) activity++;
            @(negedge clk);
        end
        n_checks++;
        if (activity != 0) begin n_fails++; $display("[TB] FAIL illegal_op: got %0d busy cycles expected 0", activity); end
    endtask

    task automatic test_no_preamble;
        int         lat, bad;
        logic       pm;
        logic [1:0] e;
        push_frame(0, 14'b01_01_00001_00000, 18'b10_0001001000000000, 1'b1);
        @(negedge clk);
        op_b = 2'b01; reg_b = 5'd0; wdata_b = 16'h1200; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = -1; bad = 0; pm = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (done_b) begin lat = n; break; end
            if (mdc_b && !pm) begin
                if (bit_q.size() == 0) bad++;
                else begin
                    e = bit_q.pop_front();
                    if (mdio_oe_b !== e[1] || (e[1] && mdio_o_b !== e[0])) bad++;
                end
            end
            pm = mdc_b;
            @(negedge clk);
        end
        bad += bit_q.size();
        bit_q.delete();
        n_checks++;
        if (lat != 66) begin n_fails++; $display("[TB] FAIL nopre_latency: got %0d expected 66", lat); end
        n_checks++;
        if (bad != 0) begin n_fails++; $display("[TB] FAIL nopre_stream: got %0d bad bits expected 0", bad); end
    endtask

    task automatic test_reset_mid_frame;
        int      rises, lat, bad;
        logic    pm;
        rd_exp_t e;
        @(negedge clk);
        op_a = 2'b01; reg_a = 5'd3; wdata_a = 16'hABCD; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        rises = 0; pm = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (mdc_a && !pm) rises++;
            pm = mdc_a;
            if (rises == 20) break;
            @(negedge clk);
        end
        n_checks++;
        if (mdio_oe_a !== 1'b1 || rises != 20) begin
            n_fails++;
            $display("[TB] FAIL midframe_driving: got oe %b rises %0d expected 1/20", mdio_oe_a, rises);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mdio_oe_a !== 1'b0) begin n_fails++; $display("[TB] FAIL midframe_release: got oe %b expected 0", mdio_oe_a); end
        @(posedge clk);
        #1;
        n_checks++;
        if ({mdc_a, mdio_oe_a, busy_a} !== 3'b000) begin
            n_fails++;
            $display("[TB] FAIL midframe_reset: got mdc/oe/busy %b expected 000", {mdc_a, mdio_oe_a, busy_a});
        end
        @(negedge clk);
        rst_n = 1'b1;
        e.data = 16'h0022; e.err = 1'b0;
        rd_q.push_back(e);
        push_frame(32, 14'b01_10_00001_00010, 18'h0, 1'b0);
        run_user(2'b10, 5'd2, 16'h0, lat, bad);
        e = rd_q.pop_front();
        n_checks++;
        if (lat != 260 || bad != 0 || rdata_a !== e.data || rd_err_a !== e.err) begin
            n_fails++;
            $display("[TB] FAIL after_reset_read: got lat %0d bad %0d data %h err %b expected 260 0 %h %b",
                     lat, bad, rdata_a, rd_err_a, e.data, e.err);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0;
        phy_regs[2] = 16'h0022;
        test_reset();
        test_write();
        test_read(1'b1, 16'h0022, 1'b0);
        test_read(1'b0, 16'hFFFF, 1'b1);
        test_poll();
        test_collision();
        test_illegal_op();
        test_no_preamble();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit");
    end
endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
Parametrised Clause-22 MDIO management master, the successor to the fixed-rate DM controller in the Ethernet subsystem. It generates MDC from the system clock with a programmable divider and supports configurable preamble length, including preamble suppression. It runs user read and write transactions and validates the PHY turnaround on reads. An optional auto-poll mode periodically reads one PHY register and flags changes, for example link status.

Parameters:
CLK_DIV, 4, half-period of MDC in clk cycles (MDC = f_clk/(2*CLK_DIV)); legal range >= 1.
PREAMBLE_BITS, 32, number of leading '1' bits per frame; legal range 0..32, where 0 = preamble suppression.
POLL_INTERVAL, 1000000, clk cycles between auto-poll launches; legal range >= 2.

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst_n  in  1  synchronous, active-low reset.
start_i  in  1  request a user transaction; sampled only when busy_o=0.
op_i  in  2  01 = write, 10 = read; 00 and 11 are illegal.
phy_addr_i  in  5  PHY address, used for both user and poll transactions.
reg_addr_i  in  5  register address for user transactions.
data_i  in  16  write data.
busy_o  out  1  high while any frame (user or poll) is in progress.
done_o  out  1  one-cycle pulse when a user transaction completes.
data_o  out  16  read data from the last user read.
rd_err_o  out  1  PHY did not drive TA bit 2 low on the last user read.
poll_en_i  in  1  enables auto-poll.
poll_reg_i  in  5  register address read by auto-poll.
poll_data_o  out  16  last valid poll result.
poll_change_o  out  1  one-cycle pulse when poll_data_o changes value.
mdc_o  out  1  management clock.
mdio_o  out  1  MDIO output data.
mdio_oe_o  out  1  MDIO output enable; the top level builds the inout from mdio_o/mdio_oe_o.
mdio_i  in  1  MDIO input data.

Behaviour:
- Reset values: mdc_o=0, mdio_o=1, mdio_oe_o=0, busy_o=0, done_o=0, data_o=0, rd_err_o=0, poll_data_o=0, poll_change_o=0, FSM=IDLE, poll counter=0.
- Reset asserted mid-frame: all outputs take reset values at the next edge and MDIO is released immediately.
- MDC:
  - Held at 0 in IDLE; toggles only during a frame.
  - Each bit period is 2*CLK_DIV cycles: MDC low for the first CLK_DIV cycles, high for the next CLK_DIV.
- Drive and sample timing:
  - Master drives mdio_o at the start of each bit period, i.e. while MDC is low.
  - mdio_i is sampled on the clk edge where mdc_o goes 0->1.
- Frame content, MSB first:
  - PREAMBLE_BITS ones, then ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
  - One trailing idle bit period follows, with oe=0 and MDC toggling.
  - Total: PREAMBLE_BITS+33 bit periods.
- Write frame: master drives TA=10 and DATA; mdio_oe_o=1 from the first preamble bit through the last data bit.
- Read frame:
  - mdio_oe_o=0 from the first TA bit to the end of the frame.
  - The sampled TA bit 2 must be 0; otherwise rd_err=1.
  - The 16 data bits are sampled into a shift register.
- FSM states: IDLE -> PREAMBLE (skipped if PREAMBLE_BITS=0) -> HEADER (14 bits) -> TA (2 bits) -> DATA (16 bits) -> END (1 bit) -> IDLE.
- Acceptance of a user request:
  - start_i is accepted in IDLE when op_i is legal.
  - The accept edge latches op, phy_addr, reg_addr and data_i.
  - busy_o=1 from the next cycle; the first bit period starts on that cycle.
- Illegal op_i: the request is ignored; no busy_o, no done_o.
- start_i while busy_o=1: ignored; it is not queued.
- Completion latency: done_o pulses, and busy_o falls in the same cycle, exactly (PREAMBLE_BITS+33)*2*CLK_DIV cycles after the first busy cycle.
- Read result registers: on a read, data_o and rd_err_o update in the done_o cycle and hold until the next user read completes. data_o takes the sampled value even when rd_err_o=1.
- Auto-poll counter:
  - Counts clk cycles while poll_en_i=1 and the FSM is in IDLE.
  - Clears to 0 when poll_en_i=0 and when a poll launches.
  - When it reaches POLL_INTERVAL-1, a read of poll_reg_i at phy_addr_i launches.
- start_i and poll launch in the same cycle: the user request wins; the poll launches on the first idle cycle after the user frame.
- Poll frames: never touch done_o, data_o or rd_err_o.
- Poll result update, at end of frame:
  - If TA bit 2 = 0 and the sampled value differs from poll_data_o: poll_data_o updates and poll_change_o pulses in the same cycle.
  - If the poll had a TA error, the result is discarded.
- Deasserting poll_en_i mid-poll: the current frame completes normally.

Test Plan:
1. CLK_DIV=2, PREAMBLE_BITS=32, write phy=1 reg=0 data=0x1200 -> mdio_o bit stream = 32×'1', 01 01 00001 00000 10 0001001000000000; mdio_oe_o=0 during the END bit; done_o pulses at cycle 260 after busy_o rises.
2. Read phy=1 reg=2, PHY model drives TA bit 2=0 and data 0x0022 -> data_o=0x0022, rd_err_o=0, mdio_oe_o=0 from the first TA bit.
3. Read with no PHY (mdio_i stuck 1) -> rd_err_o=1, data_o=0xFFFF.
4. POLL_INTERVAL=1000, poll reg 1; PHY value 0x7849 for 3 polls, then 0x786D -> exactly two poll_change_o pulses (0x0000->0x7849 and 0x7849->0x786D), and poll_data_o=0x786D.
5. start_i in the same cycle the poll counter hits 999 -> user frame runs first, then the poll frame; start_i pulsed mid-frame is ignored (no extra done_o); op_i=11 produces no busy_o.
6. PREAMBLE_BITS=0, CLK_DIV=1 write -> done_o at cycle 66. Separately, assert rst_n=0 at bit 20 of a frame -> next cycle mdc_o=0, mdio_oe_o=0, busy_o=0, and a subsequent transaction completes correctly.
